hazard_ctrl: RTL and testbench

//  Pipeline hazard/stall sequencer for the 5-stage core; sits beside the forwarding logic at ID/EX.

---
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID/EX hazard sequencer signal bundle
// Purpose: groups the ID/EX hazard inputs and the pipeline-control/MDU outputs.
// Ports (master drives, slave receives):
//   id_rs, id_rt, id_use_rs, id_use_rt, id_mdu_read      ID-stage source info
//   ex_rw, ex_memRd, ex_mdu_start, ex_mdu_op,            EX-stage info
//   ex_branch_taken
//   pc_write, ifid_write, ifid_flush, idex_flush         pipeline control (slave out)
//   mdu_busy, mdu_done, mdu_err, stall_count             MDU status / perf (slave out)
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_mdu_read;
  logic [4:0]  ex_rw;
  logic        ex_memRd;
  logic        ex_mdu_start;
  logic        ex_mdu_op;
  logic        ex_branch_taken;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        mdu_busy;
  logic        mdu_done;
  logic        mdu_err;
  logic [15:0] stall_count;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_mdu_read,
    output ex_rw, ex_memRd, ex_mdu_start, ex_mdu_op, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_flush,
    input  mdu_busy, mdu_done, mdu_err, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_mdu_read,
    input  ex_rw, ex_memRd, ex_mdu_start, ex_mdu_op, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_flush,
    output mdu_busy, mdu_done, mdu_err, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / MDU interlock and branch flush sequencer
// Purpose: stalls the front end on load-use and HI/LO-read-while-MDU-active hazards,
//   flushes wrong-path instructions on taken branches, sequences the mult/div unit
//   through IDLE/BUSY/DONE and keeps a saturating stall-cycle counter.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   hz   hazard_ctrl_if.slave bundle (ID/EX inputs, pipeline control and MDU status)
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [15:0]      stall_cnt_q;

  logic load_use;
  logic mdu_hold;
  logic stall;
  logic pc_write_c;
  logic ifid_write_c;
  logic ifid_flush_c;
  logic idex_flush_c;

  // r0 is never a real producer, so a load targeting it cannot create a hazard.
  assign load_use = hz.ex_memRd && (hz.ex_rw != 5'd0) &&
                    ((hz.id_use_rs && (hz.ex_rw == hz.id_rs)) ||
                     (hz.id_use_rt && (hz.ex_rw == hz.id_rt)));

  // A start in EX this cycle already makes HI/LO stale for the reader in ID.
  assign mdu_hold = hz.id_mdu_read && ((state != IDLE) || hz.ex_mdu_start);
  assign stall    = load_use || mdu_hold;

  // A taken branch wins over a stall: the stalled ID instruction is wrong-path anyway.
  always_comb begin
    pc_write_c   = 1'b1;
    ifid_write_c = 1'b1;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    if (rst) begin
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      idex_flush_c = 1'b1;
    end else if (hz.ex_branch_taken) begin
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
    end else if (stall) begin
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      idex_flush_c = 1'b1;
    end
  end

  assign hz.pc_write    = pc_write_c;
  assign hz.ifid_write  = ifid_write_c;
  assign hz.ifid_flush  = ifid_flush_c;
  assign hz.idex_flush  = idex_flush_c;
  assign hz.mdu_busy    = busy_q;
  assign hz.mdu_done    = done_q;
  assign hz.mdu_err     = err_q;
  assign hz.stall_count = stall_cnt_q;

  // cnt is loaded with N-1 and BUSY exits on cnt==0, giving exactly N busy cycles.
  // Starts outside IDLE never disturb the running op; they only set the sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (hz.ex_mdu_start) begin
            state  <= BUSY;
            cnt    <= hz.ex_mdu_op ? DIV_LOAD : MUL_LOAD;
            busy_q <= 1'b1;
          end
        end
        BUSY: begin
          if (hz.ex_mdu_start) err_q <= 1'b1;
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          if (hz.ex_mdu_start) err_q <= 1'b1;
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (!pc_write_c && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  hazard_ctrl_if hz ();

  hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: an MDU op is described by the cycle it started and its length.
  int cyc      = 0;
  bit m_active = 0;
  int m_start  = 0;
  int m_n      = 0;
  bit m_err    = 0;
  int m_cnt    = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic idle_inputs();
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_use_rs = 1'b0; hz.id_use_rt = 1'b0;
    hz.id_mdu_read = 1'b0; hz.ex_rw = 5'd0; hz.ex_memRd = 1'b0;
    hz.ex_mdu_start = 1'b0; hz.ex_mdu_op = 1'b0; hz.ex_branch_taken = 1'b0;
  endtask

  // Inputs are already driven (shortly after a rising edge); check mid-cycle, then advance.
  task automatic step();
    bit busy_e, done_e, nonidle, lu, hold, stall, pc_e, iw_e, if_e, xf_e;
    #2;
    busy_e  = m_active && (cyc <= m_start + m_n);
    done_e  = m_active && (cyc == m_start + m_n + 1);
    nonidle = busy_e || done_e;
    lu = hz.ex_memRd && (hz.ex_rw != 5'd0) &&
         ((hz.id_use_rs && hz.ex_rw == hz.id_rs) || (hz.id_use_rt && hz.ex_rw == hz.id_rt));
    hold  = hz.id_mdu_read && (nonidle || hz.ex_mdu_start);
    stall = lu || hold;
    if (hz.ex_branch_taken) begin
      pc_e = 1; iw_e = 1; if_e = 1; xf_e = 1;
    end else if (stall) begin
      pc_e = 0; iw_e = 0; if_e = 0; xf_e = 1;
    end else begin
      pc_e = 1; iw_e = 1; if_e = 0; xf_e = 0;
    end
    chk("pc_write",    16'(hz.pc_write),   16'(pc_e));
    chk("ifid_write",  16'(hz.ifid_write), 16'(iw_e));
    chk("ifid_flush",  16'(hz.ifid_flush), 16'(if_e));
    chk("idex_flush",  16'(hz.idex_flush), 16'(xf_e));
    chk("mdu_busy",    16'(hz.mdu_busy),   16'(busy_e));
    chk("mdu_done",    16'(hz.mdu_done),   16'(done_e));
    chk("mdu_err",     16'(hz.mdu_err),    16'(m_err));
    chk("stall_count", hz.stall_count,     16'(m_cnt));
    if (hz.ex_mdu_start) begin
      if (nonidle) m_err = 1;
      else begin
        m_active = 1; m_start = cyc; m_n = hz.ex_mdu_op ? 32 : 4;
      end
    end
    if (!pc_e && m_cnt < 65535) m_cnt++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Asserted mid-cycle so the asynchronous effect is visible before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_pc_write",    16'(hz.pc_write),   16'd0);
    chk("rst_ifid_write",  16'(hz.ifid_write), 16'd0);
    chk("rst_ifid_flush",  16'(hz.ifid_flush), 16'd0);
    chk("rst_idex_flush",  16'(hz.idex_flush), 16'd1);
    chk("rst_mdu_busy",    16'(hz.mdu_busy),   16'd0);
    chk("rst_mdu_done",    16'(hz.mdu_done),   16'd0);
    chk("rst_mdu_err",     16'(hz.mdu_err),    16'd0);
    chk("rst_stall_count", hz.stall_count,     16'd0);
    m_active = 0; m_err = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    #1;
    do_reset();

    // Load-use: one bubble, then ex_rw=0 gives no stall.
    hz.ex_memRd = 1; hz.ex_rw = 5'd5; hz.id_rs = 5'd5; hz.id_use_rs = 1;
    step();
    chk("t1_cnt_one", hz.stall_count, 16'd1);
    hz.ex_rw = 5'd0; hz.id_rs = 5'd0;
    step();
    idle_inputs();
    hz.ex_memRd = 1; hz.ex_rw = 5'd9; hz.id_rt = 5'd9; hz.id_use_rt = 1;
    step();
    hz.id_use_rt = 0;
    step();
    chk("t1_cnt_two", hz.stall_count, 16'd2);

    // Multiply with a HI/LO reader held in ID.
    idle_inputs();
    do_reset();
    hz.id_mdu_read = 1; hz.ex_mdu_start = 1; hz.ex_mdu_op = 0;
    step();
    hz.ex_mdu_start = 0;
    for (int i = 0; i < 6; i++) step();
    chk("t2_cnt_six", hz.stall_count, 16'd6);
    chk("t2_pc_free", 16'(hz.pc_write), 16'd1);

    // Taken branch during an MDU hold.
    idle_inputs();
    hz.id_mdu_read = 1; hz.ex_mdu_start = 1;
    step();
    hz.ex_mdu_start = 0;
    step();
    hz.ex_branch_taken = 1;
    step();
    hz.ex_branch_taken = 0;
    for (int i = 0; i < 5; i++) step();

    // Start during BUSY of a divide: sticky error, original completion time kept.
    idle_inputs();
    do_reset();
    hz.ex_mdu_start = 1; hz.ex_mdu_op = 1;
    step();
    hz.ex_mdu_start = 0;
    step();
    hz.ex_mdu_start = 1; hz.ex_mdu_op = 0;
    step();
    hz.ex_mdu_start = 0;
    for (int i = 3; i < 33; i++) step();
    chk("t4_done_t33", 16'(hz.mdu_done), 16'd1);
    chk("t4_err",      16'(hz.mdu_err),  16'd1);
    step();
    step();

    // Reset mid-divide: no completion afterwards.
    idle_inputs();
    do_reset();
    hz.ex_mdu_start = 1; hz.ex_mdu_op = 1;
    step();
    hz.ex_mdu_start = 0;
    for (int i = 0; i < 12; i++) step();
    do_reset();
    for (int i = 0; i < 40; i++) step();

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      hz.id_rs = 5'($urandom_range(0, 3));
      hz.id_rt = 5'($urandom_range(0, 3));
      hz.ex_rw = 5'($urandom_range(0, 3));
      hz.id_use_rs = 1'($urandom_range(0, 1));
      hz.id_use_rt = 1'($urandom_range(0, 1));
      hz.ex_memRd = ($urandom_range(0, 2) == 0);
      hz.id_mdu_read = ($urandom_range(0, 2) == 0);
      hz.ex_mdu_start = ($urandom_range(0, 9) == 0);
      hz.ex_mdu_op = ($urandom_range(0, 3) == 0);
      hz.ex_branch_taken = ($urandom_range(0, 7) == 0);
      step();
    end

    // Saturation of the stall counter.
    idle_inputs();
    do_reset();
    hz.ex_memRd = 1; hz.ex_rw = 5'd7; hz.id_rs = 5'd7; hz.id_use_rs = 1;
    for (int i = 0; i < 65540; i++) step();
    chk("t6_sat", hz.stall_count, 16'hFFFF);
    for (int i = 0; i < 4; i++) step();
    chk("t6_hold", hz.stall_count, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
